// File: rtl/y86_bus_arbiter.sv
// Two-port memory bus arbiter: CPU (port 0) and DMA/debug (port 1) share one
// memory port through an IDLE -> ACCESS -> RESP sequence with a ready timeout.
module y86_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 15,
    parameter bit          PRIO_CPU = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] mem_A,
    output logic [31:0] mem_out,
    output logic        mem_WE,
    output logic        mem_RE,
    input  logic [31:0] mem_in,
    input  logic        mem_rdy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    logic [1:0]  r_state;
    logic        r_port;
    logic        r_last;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_any;
    logic        w_pick;
    logic        w_idle;
    logic        w_acc;
    logic        w_resp;

    assign w_any  = req0 | req1;
    // Tie-break: fixed CPU priority, or the port that was not served last.
    assign w_pick = (req0 & req1) ? (PRIO_CPU ? 1'b0 : ~r_last) : req1;
    // Gated by rst_n so no grant is visible while reset is held.
    assign w_idle = (r_state == S_IDLE) & rst_n;
    assign w_acc  = (r_state == S_ACCESS);
    assign w_resp = (r_state == S_RESP);

    assign gnt0    = w_idle & w_any & ~w_pick;
    assign gnt1    = w_idle & w_any &  w_pick;

    assign mem_A   = w_acc ? r_addr  : 32'd0;
    assign mem_out = w_acc ? r_wdata : 32'd0;
    assign mem_WE  = w_acc &  r_we;
    assign mem_RE  = w_acc & ~r_we;

    assign done0   = w_resp & ~r_port;
    assign done1   = w_resp &  r_port;
    assign rdata0  = done0 ? r_rdata : 32'd0;
    assign rdata1  = done1 ? r_rdata : 32'd0;
    assign err0    = done0 & r_err;
    assign err1    = done1 & r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_port  <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_cnt   <= 8'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_port  <= w_pick;
                        r_we    <= w_pick ? we1    : we0;
                        r_addr  <= w_pick ? addr1  : addr0;
                        r_wdata <= w_pick ? wdata1 : wdata0;
                        r_cnt   <= 8'd0;
                        r_rdata <= 32'd0;
                        r_err   <= 1'b0;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Ready wins over a timeout landing on the same cycle.
                    if (mem_rdy) begin
                        r_rdata <= r_we ? 32'd0 : mem_in;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else if (r_cnt == TO_LIMIT) begin
                        r_rdata <= 32'd0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_last  <= r_port;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_y86_bus_arbiter.sv
// Directed bench for y86_bus_arbiter: expected completions are queued at grant
// time and checked by a monitor when done pulses.
module tb_y86_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, mem_rdy;
    logic [31:0] addr0, addr1, wdata0, wdata1, mem_in;
    logic        gnt0, gnt1, done0, done1, err0, err1, mem_WE, mem_RE;
    logic [31:0] rdata0, rdata1, mem_A, mem_out;
    logic        p_gnt0, p_gnt1, p_done0, p_done1, p_err0, p_err1, p_WE, p_RE;
    logic [31:0] p_rdata0, p_rdata1, p_A, p_out;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic last;
    logic p;

    always #5 clk = ~clk;

    y86_bus_arbiter #(.TIMEOUT(4), .PRIO_CPU(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_A(mem_A), .mem_out(mem_out), .mem_WE(mem_WE), .mem_RE(mem_RE),
        .mem_in(mem_in), .mem_rdy(mem_rdy)
    );

    // Fixed-priority twin driven by the same stimulus; it stays in lockstep.
    y86_bus_arbiter #(.TIMEOUT(4), .PRIO_CPU(1'b1)) u_prio (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(p_gnt0), .gnt1(p_gnt1), .done0(p_done0), .done1(p_done1),
        .rdata0(p_rdata0), .rdata1(p_rdata1), .err0(p_err0), .err1(p_err1),
        .mem_A(p_A), .mem_out(p_out), .mem_WE(p_WE), .mem_RE(p_RE),
        .mem_in(mem_in), .mem_rdy(mem_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] rd, input logic e);
        exp_t x;
        x.port  = port;
        x.rdata = rd;
        x.err   = e;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst_n && (done0 || done1)) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 32'({done1, done0}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_port", 32'({done1, done0}), mon_e.port ? 32'd2 : 32'd1);
                chk("rdata", mon_e.port ? rdata1 : rdata0, mon_e.rdata);
                chk("err", 32'(mon_e.port ? err1 : err0), 32'(mon_e.err));
                chk("unserved_zero", (mon_e.port ? rdata0 : rdata1) | 32'(mon_e.port ? err0 : err1), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 32'h100; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
        mem_rdy = 1'b0; mem_in = 32'd0;

        // Reset with a pending request: everything quiet.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk("rst_mem", 32'({mem_WE, mem_RE}) | mem_A | mem_out, 32'd0);
        chk("rst_done", 32'({done1, done0, err1, err0}) | rdata0 | rdata1, 32'd0);

        // Single read on port 0, granted as soon as reset releases.
        rst_n = 1'b1; mem_rdy = 1'b1; mem_in = 32'hDEADBEEF;
        #1;
        chk("rd_gnt", 32'({gnt1, gnt0}), 32'd1);
        push(1'b0, 32'hDEADBEEF, 1'b0);
        @(negedge clk); #1;
        chk("rd_RE", 32'({mem_WE, mem_RE}), 32'd1);
        chk("rd_A", mem_A, 32'h100);
        chk("rd_no_gnt_access", 32'({gnt1, gnt0}), 32'd0);
        req0 = 1'b0; addr0 = 32'hFFF;
        @(negedge clk); #1;
        chk("rd_done", 32'(done0), 32'd1);
        chk("rd_mem_idle", 32'({mem_WE, mem_RE}) | mem_A, 32'd0);
        @(negedge clk); #1;

        // Write on port 1.
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h12345678;
        #1;
        chk("wr_gnt", 32'({gnt1, gnt0}), 32'd2);
        push(1'b1, 32'd0, 1'b0);
        @(negedge clk); #1;
        chk("wr_WE", 32'({mem_WE, mem_RE}), 32'd2);
        chk("wr_A", mem_A, 32'h40);
        chk("wr_out", mem_out, 32'h12345678);
        req1 = 1'b0; we1 = 1'b0; wdata1 = 32'hBAD0BAD0;
        @(negedge clk); #1;
        chk("wr_done", 32'(done1), 32'd1);
        @(negedge clk); #1;

        // Timeout: five ACCESS cycles, then err with zero data.
        req0 = 1'b1; addr0 = 32'h200; mem_rdy = 1'b0; mem_in = 32'hAAAA5555;
        #1;
        chk("to_gnt", 32'({gnt1, gnt0}), 32'd1);
        push(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("to_access", 32'(mem_RE), 32'd1);
            req0 = 1'b0;
        end
        @(negedge clk); #1;
        chk("to_done", 32'(done0), 32'd1);
        chk("to_mem_idle", 32'(mem_RE), 32'd0);
        @(negedge clk); #1;

        // Ready on the final count cycle succeeds; port 1 pulses req meanwhile.
        req0 = 1'b1; addr0 = 32'h300; mem_in = 32'h5555AAAA;
        #1;
        chk("edge_gnt", 32'({gnt1, gnt0}), 32'd1);
        push(1'b0, 32'h5555AAAA, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("edge_access", 32'(mem_RE), 32'd1);
            req0 = 1'b0;
            if (i == 1) begin
                req1 = 1'b1; #1;
                chk("wd_no_gnt1", 32'(gnt1), 32'd0);
            end
            if (i == 2) req1 = 1'b0;
            if (i == 4) mem_rdy = 1'b1;
        end
        @(negedge clk); #1;
        chk("edge_done", 32'(done0), 32'd1);
        @(negedge clk); #1;
        chk("wd_idle_quiet", 32'({gnt1, gnt0, mem_WE, mem_RE}), 32'd0);

        // Round-robin with both requesting; fixed-priority twin keeps port 0.
        last = 1'b0;
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'hA0; addr1 = 32'hB0;
        for (int k = 0; k < 4; k++) begin
            p = ~last;
            mem_in = 32'hC0DE0000 + 32'(k);
            #1;
            chk("rr_gnt", 32'({gnt1, gnt0}), p ? 32'd2 : 32'd1);
            chk("prio_gnt", 32'({p_gnt1, p_gnt0}), 32'd1);
            push(p, 32'hC0DE0000 + 32'(k), 1'b0);
            last = p;
            @(negedge clk); #1;
            chk("rr_A", mem_A, p ? 32'hB0 : 32'hA0);
            @(negedge clk); #1;
            chk("rr_done", 32'({done1, done0}), p ? 32'd2 : 32'd1);
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
            @(negedge clk);
        end
        #1;

        // Reset during ACCESS: strobes drop at once, no done, tie goes to port 0.
        req0 = 1'b1; addr0 = 32'h500; mem_rdy = 1'b0;
        #1;
        chk("rs_gnt", 32'({gnt1, gnt0}), 32'd1);
        @(negedge clk); #1;
        chk("rs_access", 32'(mem_RE), 32'd1);
        #2 rst_n = 1'b0; req1 = 1'b1;
        #1;
        chk("rs_async_drop", 32'({mem_WE, mem_RE}) | mem_A, 32'd0);
        @(negedge clk); #1;
        chk("rs_quiet", 32'({gnt1, gnt0, done1, done0}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; mem_rdy = 1'b1; mem_in = 32'h600DF00D;
        #1;
        chk("rs_tie_gnt0", 32'({gnt1, gnt0}), 32'd1);
        push(1'b0, 32'h600DF00D, 1'b0);
        @(negedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk); #1;
        chk("rs_done", 32'(done0), 32'd1);
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
